// File: rtl/xor_stream_cipher.sv
// Chunked XOR block cipher with static, rotating and Galois-LFSR keystreams.
// One KEY_SIZE chunk is processed per enabled cycle between a start pulse and a done pulse.
module xor_stream_cipher #(
  parameter int                  MSG_SIZE   = 64,
  parameter int                  KEY_SIZE   = 8,
  parameter logic [KEY_SIZE-1:0] LFSR_TAPS  = KEY_SIZE'(8'hB8),
  localparam int                 NUM_CHUNKS = MSG_SIZE / KEY_SIZE,
  localparam int                 CW         = $clog2(NUM_CHUNKS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                iStart,
  input  logic [1:0]          iMode,
  input  logic [MSG_SIZE-1:0] iMessage,
  input  logic [KEY_SIZE-1:0] iKey,
  output logic                oBusy,
  output logic                oDone,
  output logic                oValid,
  output logic [CW-1:0]       oChunk_counter,
  output logic [MSG_SIZE-1:0] oCiphertext
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;

  state_t              state_reg, state_next;
  logic [MSG_SIZE-1:0] msg_reg,   msg_next;
  logic [1:0]          mode_reg,  mode_next;
  logic [KEY_SIZE-1:0] ks_reg,    ks_next;
  logic [MSG_SIZE-1:0] ct_reg,    ct_next;
  logic [CW-1:0]       cnt_reg,   cnt_next;
  logic                busy_reg,  busy_next;
  logic                done_reg,  done_next;
  logic                valid_reg, valid_next;

  logic [KEY_SIZE-1:0] ks_step;
  logic [KEY_SIZE-1:0] ks_seed;
  logic [MSG_SIZE-1:0] ct_written;
  logic                last_chunk;

  // Keystream advance; the reserved mode behaves like the static key.
  always_comb begin
    ks_step = ks_reg;
    case (mode_reg)
      MODE_ROTATE: ks_step = {ks_reg[KEY_SIZE-2:0], ks_reg[KEY_SIZE-1]};
      MODE_LFSR:   ks_step = ks_reg[0] ? ((ks_reg >> 1) ^ LFSR_TAPS) : (ks_reg >> 1);
      default:     ks_step = ks_reg;
    endcase
  end

  // A zero seed would lock the LFSR at zero forever, so it is promoted to 1.
  assign ks_seed = ((iMode == MODE_LFSR) && (iKey == '0)) ? KEY_SIZE'(1) : iKey;

  assign last_chunk = (cnt_reg == CW'(NUM_CHUNKS - 1));

  // Only the chunk addressed by the counter picks up the new XOR result.
  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      assign ct_written[gi*KEY_SIZE +: KEY_SIZE] =
        (cnt_reg == CW'(gi)) ? (msg_reg[gi*KEY_SIZE +: KEY_SIZE] ^ ks_reg)
                             : ct_reg[gi*KEY_SIZE +: KEY_SIZE];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      msg_reg   <= '0;
      mode_reg  <= '0;
      ks_reg    <= '0;
      ct_reg    <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      msg_reg   <= msg_next;
      mode_reg  <= mode_next;
      ks_reg    <= ks_next;
      ct_reg    <= ct_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    mode_next  = mode_reg;
    ks_next    = ks_reg;
    ct_next    = ct_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    valid_next = valid_reg;

    case (state_reg)
      S_IDLE: begin
        if (ena && iStart) begin
          msg_next   = iMessage;
          mode_next  = iMode;
          ks_next    = ks_seed;
          ct_next    = '0;
          cnt_next   = '0;
          valid_next = 1'b0;
          busy_next  = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (ena) begin
          ct_next  = ct_written;
          cnt_next = cnt_reg + CW'(1);
          ks_next  = ks_step;
          if (last_chunk) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            valid_next = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The done pulse always ends after one cycle; leaving DONE still waits for ena.
        done_next = 1'b0;
        if (ena) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign oBusy          = busy_reg;
  assign oDone          = done_reg;
  assign oValid         = valid_reg;
  assign oChunk_counter = cnt_reg;
  assign oCiphertext    = ct_reg;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher: directed vectors, stall, reset abort,
// and randomized blocks against a chunk-by-chunk keystream reference model.
module tb_xor_stream_cipher;

  localparam int MSG_SIZE   = 32;
  localparam int KEY_SIZE   = 8;
  localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
  localparam int CW         = $clog2(NUM_CHUNKS) + 1;

  logic                clk;
  logic                rst_n;
  logic                ena;
  logic                iStart;
  logic [1:0]          iMode;
  logic [MSG_SIZE-1:0] iMessage;
  logic [KEY_SIZE-1:0] iKey;
  logic                oBusy;
  logic                oDone;
  logic                oValid;
  logic [CW-1:0]       oChunk_counter;
  logic [MSG_SIZE-1:0] oCiphertext;

  int checks_cnt = 0;
  int errors_cnt = 0;

  xor_stream_cipher #(
    .MSG_SIZE  (MSG_SIZE),
    .KEY_SIZE  (KEY_SIZE),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .iStart         (iStart),
    .iMode          (iMode),
    .iMessage       (iMessage),
    .iKey           (iKey),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oValid         (oValid),
    .oChunk_counter (oChunk_counter),
    .oCiphertext    (oCiphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list the keystream byte for each chunk, then XOR chunk by chunk.
  function automatic logic [31:0] model(input logic [31:0] m, input logic [7:0] k,
                                        input logic [1:0] md);
    int          key_list [NUM_CHUNKS];
    int          cur;
    logic [31:0] r;
    cur = int'(k);
    if (md == 2 && cur == 0) cur = 1;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      key_list[c] = cur;
      if (md == 1)      cur = ((cur * 2) % 256) + (cur / 128);
      else if (md == 2) cur = (cur % 2 == 1) ? ((cur / 2) ^ 'hB8) : (cur / 2);
    end
    r = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      r = r | (32'((int'(m[c*8 +: 8]) ^ key_list[c]) & 'hFF) << (c * 8));
    end
    return r;
  endfunction

  // Runs one block from start to done; stall_pct randomly drops ena and pulses iStart.
  task automatic run_block(input string tag, input logic [31:0] m, input logic [7:0] k,
                           input logic [1:0] md, input logic [31:0] exp, input int stall_pct);
    int ena_edges;
    int waited;
    @(negedge clk);
    iMessage = m; iKey = k; iMode = md; iStart = 1'b1; ena = 1'b1;
    @(negedge clk);
    check_eq({tag, "_busy"}, oBusy, 1);
    check_eq({tag, "_cnt0"}, oChunk_counter, 0);
    iStart = 1'b0; iMessage = $urandom; iKey = KEY_SIZE'($urandom); iMode = 2'($urandom);
    ena_edges = 0;
    waited = 0;
    while (!oDone && waited < 200) begin
      ena = ($urandom_range(99) >= stall_pct);
      if (stall_pct > 0) iStart = 1'($urandom_range(1));
      if (ena) ena_edges++;
      @(negedge clk);
      waited++;
    end
    iStart = 1'b0;
    ena = 1'b1;
    check_eq({tag, "_done_seen"}, oDone, 1);
    check_eq({tag, "_latency"}, ena_edges, NUM_CHUNKS);
    check_eq({tag, "_ct"}, oCiphertext, exp);
    check_eq({tag, "_valid"}, oValid, 1);
    check_eq({tag, "_cnt"}, oChunk_counter, NUM_CHUNKS);
    check_eq({tag, "_busy_lo"}, oBusy, 0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, oDone, 0);
    check_eq({tag, "_hold_valid"}, oValid, 1);
    check_eq({tag, "_hold_ct"}, oCiphertext, exp);
    $display("blk %s mode=%0d msg=%h key=%h ct=%h exp=%h edges=%0d", tag, md, m, k,
             oCiphertext, exp, ena_edges);
  endtask

  initial begin
    int          n;
    logic        seen_done;
    logic [31:0] rm;
    logic [7:0]  rk;
    logic [1:0]  rmd;

    rst_n = 1'b0; ena = 1'b0; iStart = 1'b0; iMode = '0; iMessage = '0; iKey = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", oBusy, 0);
    check_eq("rst_done", oDone, 0);
    check_eq("rst_valid", oValid, 0);
    check_eq("rst_cnt", oChunk_counter, 0);
    check_eq("rst_ct", oCiphertext, 0);
    rst_n = 1'b1;

    // Start without ena must not launch a block.
    @(negedge clk);
    iStart = 1'b1; ena = 1'b0; iMessage = 32'h12345678; iKey = 8'h55;
    @(negedge clk);
    check_eq("noena_busy", oBusy, 0);
    iStart = 1'b0;

    run_block("m0",    32'h11223344, 8'hAA, 2'd0, 32'hBB8899EE, 0);
    run_block("m1",    32'h00000000, 8'h81, 2'd1, 32'h0C060381, 0);
    run_block("m2k1",  32'h00000000, 8'h01, 2'd2, 32'h2E5CB801, 0);
    run_block("m2k0",  32'h00000000, 8'h00, 2'd2, 32'h2E5CB801, 0);
    run_block("trip",  32'hBB8899EE, 8'hAA, 2'd0, 32'h11223344, 0);
    run_block("m3",    32'h11223344, 8'hAA, 2'd3, 32'hBB8899EE, 0);

    // Stall for three cycles after chunk 1 has been written.
    @(negedge clk);
    iMessage = 32'h11223344; iKey = 8'hAA; iMode = 2'd0; iStart = 1'b1; ena = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stall_cnt2", oChunk_counter, 2);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stall_hold_cnt", oChunk_counter, 2);
    check_eq("stall_partial", oCiphertext, 32'h000099EE);
    check_eq("stall_busy", oBusy, 1);
    check_eq("stall_nodone", oDone, 0);
    ena = 1'b1;
    n = 0;
    while (!oDone && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_remaining", n, 2);
    check_eq("stall_ct", oCiphertext, 32'hBB8899EE);
    @(negedge clk);
    check_eq("stall_pulse", oDone, 0);
    $display("blk stall mode=0 msg=11223344 key=aa ct=%h", oCiphertext);

    // Re-pulsed start while busy, then reset abort at counter 2.
    @(negedge clk);
    iMessage = 32'h00000000; iKey = 8'h81; iMode = 2'd1; iStart = 1'b1; ena = 1'b1;
    @(negedge clk);
    iMessage = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check_eq("restart_ignored_cnt", oChunk_counter, 2);
    check_eq("restart_ignored_ct", oCiphertext, 32'h00000381);
    iStart = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", oBusy, 0);
    check_eq("abort_done", oDone, 0);
    check_eq("abort_valid", oValid, 0);
    check_eq("abort_cnt", oChunk_counter, 0);
    check_eq("abort_ct", oCiphertext, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (oDone || oBusy) seen_done = 1'b1;
    end
    check_eq("abort_quiet", seen_done, 0);
    $display("blk abort mode=1 cnt=%0d ct=%h", oChunk_counter, oCiphertext);

    for (int t = 0; t < 24; t++) begin
      rm  = $urandom;
      rk  = (t % 6 == 0) ? 8'h00 : KEY_SIZE'($urandom);
      rmd = 2'($urandom_range(3));
      run_block($sformatf("rnd%0d", t), rm, rk, rmd, model(rm, rk, rmd), (t % 2) ? 30 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
